// File: rtl/riscv_regfile_pkg.sv
// rtl/riscv_regfile_pkg.sv - shared constants and write-port arbitration for the register file
package riscv_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int X0        = 0;

  // Widest write-port set the arbitration helper accepts; callers zero-extend
  // their per-port hit vectors to this width.
  localparam int MAX_WR = 32;

  // Index of the highest-numbered asserted hit bit (the winning write port).
  // Returns 0 when no bit is set; callers qualify the result with |hit.
  function automatic int win_port(input logic [MAX_WR-1:0] hit);
    int w;
    w = 0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/riscv_regfile_bypass.sv
// rtl/riscv_regfile_bypass.sv - per-read-port mux between stored data and same-cycle write data
module riscv_regfile_bypass
  import riscv_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] stored_data,
  input  logic            byp_valid,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] rd_data
);

  // A write landing on this port's address this cycle overrides the stored value.
  assign rd_data = byp_valid ? byp_data : stored_data;

endmodule

// File: rtl/riscv_regfile_mp.sv
// rtl/riscv_regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                resv_en,
  input  logic [AW-1:0]       resv_addr,
  input  logic                flush,
  output logic                busy_any,
  output logic                wr_conflict
);

  logic [XLEN-1:0]  mem    [NREGS];
  logic [XLEN-1:0]  reg_wd [NREGS];
  logic [NREGS-1:0] reg_we;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             dup_wr;

  // Resolve, per register, whether any port writes it and which port's data wins.
  always_comb begin
    logic [MAX_WR-1:0] hit;
    int                w;
    for (int r = 0; r < NREGS; r++) begin
      hit = '0;
      for (int i = 0; i < NWR; i++) begin
        hit[i] = wr_en[i] && (wr_addr[i*AW +: AW] == AW'(r));
      end
      w         = win_port(hit);
      reg_we[r] = (r != X0) && (|hit);
      reg_wd[r] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (i == w) reg_wd[r] = wr_data[i*XLEN +: XLEN];
      end
    end
  end

  // Register storage; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (reg_we[r]) mem[r] <= reg_wd[r];
      end
    end
  end

  // Busy next state: write clears, reservation sets, flush clears everything; x0 never busy.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_nxt[r] = busy[r];
      if (reg_we[r]) busy_nxt[r] = 1'b0;
      if (resv_en && (resv_addr == AW'(r))) busy_nxt[r] = 1'b1;
      if (flush) busy_nxt[r] = 1'b0;
      if (r == X0) busy_nxt[r] = 1'b0;
    end
  end

  // Detect two or more enabled ports aimed at the same nonzero register.
  always_comb begin
    dup_wr = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &&
            (wr_addr[i*AW +: AW] != AW'(X0)))
          dup_wr = 1'b1;
      end
    end
  end

  // Scoreboard bits and the one-cycle conflict pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      wr_conflict <= dup_wr;
    end
  end

  assign busy_any = |busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [MAX_WR-1:0] hit;
    logic [XLEN-1:0]   byp_data;
    logic              byp_valid;
    int                w;

    assign ra = rd_addr[p*AW +: AW];

    // Find the winning same-cycle write to this port's address; held off during reset.
    always_comb begin
      hit = '0;
      for (int i = 0; i < NWR; i++) begin
        hit[i] = rst_n && wr_en[i] && (wr_addr[i*AW +: AW] == ra);
      end
      w         = win_port(hit);
      byp_valid = (ra != AW'(X0)) && (|hit);
      byp_data  = '0;
      for (int i = 0; i < NWR; i++) begin
        if (i == w) byp_data = wr_data[i*XLEN +: XLEN];
      end
    end

    // A same-cycle write hides the busy bit unless the register is re-reserved now.
    assign rd_busy[p] = busy[ra] && !(byp_valid && !(resv_en && (resv_addr == ra)));

    riscv_regfile_bypass #(
      .XLEN (XLEN)
    ) u_bypass (
      .stored_data (mem[ra]),
      .byp_valid   (byp_valid),
      .byp_data    (byp_data),
      .rd_data     (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// tb/tb_riscv_regfile_mp.sv - self-checking bench for riscv_regfile_mp in two parameter sets
module tb_riscv_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: XLEN 32, NREGS 32, NRD 2, NWR 2
  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic [1:0]   a_wr_en;
  logic [9:0]   a_wr_addr;
  logic [63:0]  a_wr_data;
  logic         a_resv_en;
  logic [4:0]   a_resv_addr;
  logic         a_flush;
  logic         a_busy_any;
  logic         a_wr_conflict;

  // Instance B: XLEN 64, NREGS 16, NRD 3, NWR 1
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_resv_en;
  logic [3:0]   b_resv_addr;
  logic         b_flush;
  logic         b_busy_any;
  logic         b_wr_conflict;

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .rd_addr (a_rd_addr), .rd_data (a_rd_data), .rd_busy (a_rd_busy),
    .wr_en (a_wr_en), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
    .resv_en (a_resv_en), .resv_addr (a_resv_addr), .flush (a_flush),
    .busy_any (a_busy_any), .wr_conflict (a_wr_conflict)
  );

  riscv_regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .rd_addr (b_rd_addr), .rd_data (b_rd_data), .rd_busy (b_rd_busy),
    .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_data (b_wr_data),
    .resv_en (b_resv_en), .resv_addr (b_resv_addr), .flush (b_flush),
    .busy_any (b_busy_any), .wr_conflict (b_wr_conflict)
  );

  // Generic stimulus, packed onto whichever instance is active
  int          cfg;
  int          nrd, nwr, nregs;
  logic [63:0] mask;
  int          s_rd_addr [3];
  bit          s_wr_en   [2];
  int          s_wr_addr [2];
  logic [63:0] s_wr_data [2];
  bit          s_resv_en;
  int          s_resv_addr;
  bit          s_flush;

  always_comb begin
    a_rd_addr   = {5'(s_rd_addr[1]), 5'(s_rd_addr[0])};
    a_wr_en     = (cfg == 0) ? {s_wr_en[1], s_wr_en[0]} : 2'b00;
    a_wr_addr   = {5'(s_wr_addr[1]), 5'(s_wr_addr[0])};
    a_wr_data   = {s_wr_data[1][31:0], s_wr_data[0][31:0]};
    a_resv_en   = (cfg == 0) && s_resv_en;
    a_resv_addr = 5'(s_resv_addr);
    a_flush     = (cfg == 0) && s_flush;
    b_rd_addr   = {4'(s_rd_addr[2]), 4'(s_rd_addr[1]), 4'(s_rd_addr[0])};
    b_wr_en     = (cfg == 1) ? s_wr_en[0] : 1'b0;
    b_wr_addr   = 4'(s_wr_addr[0]);
    b_wr_data   = s_wr_data[0];
    b_resv_en   = (cfg == 1) && s_resv_en;
    b_resv_addr = 4'(s_resv_addr);
    b_flush     = (cfg == 1) && s_flush;
  end

  function automatic logic [63:0] get_rd(input int p);
    if (cfg == 0) return {32'h0, a_rd_data[p*32 +: 32]};
    return b_rd_data[p*64 +: 64];
  endfunction

  function automatic logic get_busy(input int p);
    if (cfg == 0) return a_rd_busy[p];
    return b_rd_busy[p];
  endfunction

  function automatic logic get_busy_any();
    return (cfg == 0) ? a_busy_any : b_busy_any;
  endfunction

  function automatic logic get_conflict();
    return (cfg == 0) ? a_wr_conflict : b_wr_conflict;
  endfunction

  // Reference model: architectural state only
  logic [63:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_conf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cfg=%0d got=%h exp=%h", tag, cfg, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [63:0] exp_rd(input int p);
    int          a;
    logic [63:0] v;
    a = s_rd_addr[p];
    if (a == 0) return '0;
    v = m_mem[a];
    for (int i = 0; i < nwr; i++) begin
      if (s_wr_en[i] && s_wr_addr[i] == a) v = s_wr_data[i] & mask;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int p);
    int a;
    bit written;
    a = s_rd_addr[p];
    if (a == 0) return 1'b0;
    written = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      if (s_wr_en[i] && s_wr_addr[i] == a) written = 1'b1;
    end
    if (written && !(s_resv_en && s_resv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_busy_any();
    for (int r = 0; r < 32; r++) begin
      if (m_busy[r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply one clock edge worth of architectural effects
  task automatic model_commit();
    int cnt [32];
    bit wr  [32];
    for (int r = 0; r < 32; r++) begin
      cnt[r] = 0;
      wr[r]  = 1'b0;
    end
    for (int i = 0; i < nwr; i++) begin
      if (s_wr_en[i] && s_wr_addr[i] != 0) begin
        m_mem[s_wr_addr[i]] = s_wr_data[i] & mask;
        wr[s_wr_addr[i]]    = 1'b1;
        cnt[s_wr_addr[i]]++;
      end
    end
    m_conf = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cnt[r] >= 2) m_conf = 1'b1;
      if (wr[r]) m_busy[r] = 1'b0;
      if (s_resv_en && s_resv_addr == r) m_busy[r] = 1'b1;
      if (s_flush) m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) s_rd_addr[p] = 0;
    for (int i = 0; i < 2; i++) begin
      s_wr_en[i]   = 1'b0;
      s_wr_addr[i] = 0;
      s_wr_data[i] = '0;
    end
    s_resv_en   = 1'b0;
    s_resv_addr = 0;
    s_flush     = 1'b0;
  endtask

  task automatic settle_check();
    @(negedge clk);
    for (int p = 0; p < nrd; p++) begin
      chk($sformatf("rd_data%0d", p), get_rd(p), exp_rd(p));
      chk($sformatf("rd_busy%0d", p), 64'(get_busy(p)), 64'(exp_busy(p)));
    end
    chk("busy_any", 64'(get_busy_any()), 64'(exp_busy_any()));
    chk("wr_conflict", 64'(get_conflict()), 64'(m_conf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 1) == 1) return $urandom_range(0, 3);
    return $urandom_range(0, nregs - 1);
  endfunction

  task automatic run_cfg(input int c);
    cfg   = c;
    nrd   = (c == 0) ? 2 : 3;
    nwr   = (c == 0) ? 2 : 1;
    nregs = (c == 0) ? 32 : 16;
    mask  = (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    do_reset();

    // Reset state
    idle();
    s_rd_addr[0] = 5;
    settle_check();
    tick();

    // Write and reserve x5, then reset between edges
    idle();
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 5; s_wr_data[0] = 64'hDEADBEEF;
    s_resv_en = 1'b1; s_resv_addr = 5;
    settle_check();
    tick();
    idle();
    s_rd_addr[0] = 5;
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 6; s_wr_data[0] = 64'h1111;
    settle_check();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_x5", get_rd(0), 64'h0);
    chk("rst_busy_any", 64'(get_busy_any()), 64'h0);
    chk("rst_rd_busy", 64'(get_busy(0)), 64'h0);
    model_clear();
    idle();
    s_rd_addr[0] = 5;
    settle_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    settle_check();
    tick();

    // Bypass on read port 1
    idle();
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 7; s_wr_data[0] = 64'h12345678;
    s_rd_addr[1] = 7;
    settle_check();
    chk("byp_x7", get_rd(1), 64'h12345678);
    tick();

    // x0 writes are dropped and never conflict
    idle();
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 0; s_wr_data[0] = 64'hFFFFFFFF;
    s_wr_en[1] = 1'b1; s_wr_addr[1] = 0; s_wr_data[1] = 64'hFFFFFFFF;
    settle_check();
    chk("x0_byp", get_rd(0), 64'h0);
    tick();
    idle();
    settle_check();
    chk("x0_conflict", 64'(get_conflict()), 64'h0);
    chk("x0_stored", get_rd(0), 64'h0);
    tick();

    // Priority between write ports on x3
    idle();
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 3; s_wr_data[0] = 64'hAAAA0000;
    s_wr_en[1] = 1'b1; s_wr_addr[1] = 3; s_wr_data[1] = 64'h0000BBBB;
    s_rd_addr[0] = 3;
    settle_check();
    tick();
    idle();
    s_rd_addr[0] = 3;
    settle_check();
    chk("prio_x3", get_rd(0), (nwr > 1) ? 64'h0000BBBB : 64'hAAAA0000);
    chk("prio_conflict", 64'(get_conflict()), (nwr > 1) ? 64'h1 : 64'h0);
    tick();
    settle_check();
    chk("conflict_pulse_end", 64'(get_conflict()), 64'h0);
    tick();

    // Scoreboard on x9
    idle();
    s_resv_en = 1'b1; s_resv_addr = 9;
    s_rd_addr[0] = 9;
    settle_check();
    tick();
    idle();
    s_rd_addr[0] = 9;
    settle_check();
    chk("resv_x9", 64'(get_busy(0)), 64'h1);
    tick();
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 9; s_wr_data[0] = 64'h5;
    settle_check();
    chk("wr_x9_busy", 64'(get_busy(0)), 64'h0);
    chk("wr_x9_data", get_rd(0), 64'h5);
    tick();
    idle();
    s_rd_addr[0] = 9;
    settle_check();
    chk("x9_after", 64'(get_busy(0)), 64'h0);
    tick();

    // Reserve and write x4 together, then reserve with flush
    idle();
    s_resv_en = 1'b1; s_resv_addr = 4;
    s_wr_en[0] = 1'b1; s_wr_addr[0] = 4; s_wr_data[0] = 64'h44;
    s_rd_addr[0] = 4;
    settle_check();
    tick();
    idle();
    s_rd_addr[0] = 4;
    settle_check();
    chk("x4_busy", 64'(get_busy(0)), 64'h1);
    chk("x4_data", get_rd(0), 64'h44);
    s_resv_en = 1'b1; s_resv_addr = 4; s_flush = 1'b1;
    tick();
    idle();
    s_rd_addr[0] = 4;
    settle_check();
    chk("flush_x4", 64'(get_busy(0)), 64'h0);
    chk("flush_any", 64'(get_busy_any()), 64'h0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 3; p++) s_rd_addr[p] = rnd_addr();
      for (int i = 0; i < 2; i++) begin
        s_wr_en[i]   = ($urandom_range(0, 2) != 0);
        s_wr_addr[i] = rnd_addr();
        s_wr_data[i] = {$urandom, $urandom};
      end
      s_resv_en   = ($urandom_range(0, 2) == 0);
      s_resv_addr = rnd_addr();
      s_flush     = ($urandom_range(0, 15) == 0);
      settle_check();
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg   = 0;
    nrd   = 2;
    nwr   = 2;
    nregs = 32;
    mask  = 64'h0000_0000_FFFF_FFFF;
    idle();
    model_clear();
    run_cfg(0);
    run_cfg(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_mp.md
# riscv_regfile_mp

Parametrised multi-port integer register file, the next generation of the core's register file. It is used by the pipelined datapath. It provides NRD combinational read ports and NWR prioritised write ports, with same-cycle write-to-read bypass. A per-register busy scoreboard lets decode detect RAW hazards on destinations still in flight. Writes move to the rising edge. Register 0 stays hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- AW, $clog2(NREGS), address width (derived, not overridable)

Clock and reset are decided: one clock; reset is asynchronous and active-low.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses; port p is bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port p is bits [p*XLEN +: XLEN]
- rd_busy  out  NRD  port p's register has an outstanding reservation
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- resv_en  in  1  reserve destination resv_addr (set busy bit)
- resv_addr  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline flush); data untouched
- busy_any  out  1  OR of all busy bits
- wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same nonzero address last cycle

## Operation
- Storage: NREGS×XLEN registers, plus NREGS busy bits, plus the wr_conflict flop.
- Register 0 behaviour:
  - reads as 0; writes to it are dropped.
  - reserving it is ignored; busy[0] is always 0.
  - it never counts toward wr_conflict.
- Write priority: when several enabled ports hit the same address, the highest-index port wins. The other ports are discarded for that address.
- Bypass: rd_data[p] returns the winning same-cycle write data when the same address is being written (wr_en high, address nonzero). Otherwise it returns stored data. Bypass is combinational.
- Busy update per register r (r ≠ 0), evaluated in this order:
  - written this cycle (any port) → clear.
  - resv_en && resv_addr == r → set. Reservation beats a same-cycle write to r.
  - flush → clear. Flush beats both write and reservation.
- rd_busy[p] is combinational from the current busy bits. The same-cycle write clear is bypassed as well: a port reading a register written this cycle sees rd_busy = 0, unless that register is also being reserved this cycle.
- wr_conflict goes high for exactly one cycle after any cycle with a duplicate nonzero write address among enabled ports.
- Width rule: addresses ≥ NREGS cannot occur (NREGS is a power of two); no range check.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - all registers to 0
  - all busy bits to 0
  - wr_conflict, busy_any and rd_busy to 0
  - rd_data to 0
- Reset release: the first rising edge with rst_n high performs normal updates.
- Write latency: data is stored at the rising edge. Via bypass, it is visible on rd_data in the same cycle; from storage, from the next cycle.
- Reservation latency: busy is visible on rd_busy the cycle after resv_en.
- Reset asserted mid-operation discards any in-flight write, reservation and conflict pulse immediately; outputs go to their reset values without waiting for a clock edge.
- No handshake: every input is sampled every cycle; no stalls are generated internally.

## Structure
- Shared package riscv_regfile_pkg holds:
  - default XLEN and NREGS constants
  - the x0 index constant
  - a function that resolves the winning write port for an address (highest-index priority), used by both the storage update and the bypass logic.
- One sub-module, riscv_regfile_bypass: per-read-port mux choosing between stored data and the winning write data. It is instantiated NRD times in a generate loop.
- The scoreboard stays in the top module; it is not a separate block.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pull rst_n low between edges → rd_data for x5 reads 0 immediately and busy_any = 0.
- Bypass and x0:
  - write port 0 x7 = 0x12345678 with read port 1 on x7 → same-cycle rd_data = 0x12345678.
  - write x0 = 0xFFFFFFFF → x0 reads 0 and wr_conflict stays 0.
- Priority: ports 0 and 1 both write x3, with 0xAAAA0000 and 0x0000BBBB → x3 = 0x0000BBBB, and wr_conflict = 1 for exactly the next cycle.
- Scoreboard:
  - reserve x9 → rd_busy = 1 the next cycle.
  - write x9 = 5 → same-cycle rd_busy = 0 and rd_data = 5; the busy bit stays clear afterward.
- Simultaneous events:
  - reserve and write x4 in the same cycle → x4 is busy next cycle, data updated.
  - reserve x4 with flush in the same cycle → x4 is not busy; busy_any = 0.
- Parameters: re-run all of the above with NRD = 3, NWR = 1, NREGS = 16, XLEN = 64 → identical behaviour with widened and narrowed buses.
